// File: rtl/hazard_scoreboard_unit.sv
// Load-use scoreboard and control-hazard stall unit for the ID stage.
// Optional stall statistics counter enabled by defining HDU_STALL_COUNT_EN.
module hazard_scoreboard_unit #(
    parameter int NUM_REGS       = 32,
    parameter int REG_AW         = 5,
    parameter int LOAD_LATENCY   = 1,
    parameter int BRANCH_PENALTY = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IDU_Valid,
    input  logic [REG_AW-1:0] IDU_RsReg,
    input  logic [REG_AW-1:0] IDU_RtReg,
    input  logic              IDU_UsesRs,
    input  logic              IDU_UsesRt,
    input  logic [REG_AW-1:0] IDU_DstReg,
    input  logic              IDU_IsLoad,
    input  logic              IDU_Jump,
    output logic              Stall,
    output logic [1:0]        HazardType,
    output logic [15:0]       StallCount
);

    typedef enum logic {
        IDLE,
        CTRL_WAIT
    } ctrl_state_e;

    typedef enum logic [1:0] {
        HZ_NONE     = 2'b00,
        HZ_LOAD_USE = 2'b01,
        HZ_CONTROL  = 2'b10,
        HZ_RESET    = 2'b11
    } hazard_e;

    localparam logic [2:0] LOAD_CNT   = 3'(LOAD_LATENCY);
    localparam logic [2:0] BRANCH_CNT = 3'(BRANCH_PENALTY);

    logic [2:0]  sb_cnt [NUM_REGS];
    logic        rs_pending;
    logic        rt_pending;
    logic        load_use;
    logic        ctrl_stall;
    logic        stall;
    logic        accept;
    logic        set_entry;
    ctrl_state_e state, state_next;
    logic [2:0]  ctrl_cnt, ctrl_cnt_next;
    hazard_e     hazard;

    // Register lookup is a compare loop so an address beyond NUM_REGS reads as not pending.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rs_pending = 1'b0;
        rt_pending = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (IDU_RsReg == REG_AW'(i) && sb_cnt[i] != 3'd0) rs_pending = 1'b1;
            if (IDU_RtReg == REG_AW'(i) && sb_cnt[i] != 3'd0) rt_pending = 1'b1;
        end
    end

    assign load_use   = IDU_Valid & ((IDU_UsesRs & rs_pending) | (IDU_UsesRt & rt_pending));
    assign ctrl_stall = (state == CTRL_WAIT);
    assign stall      = Reset | ctrl_stall | load_use;
    assign accept     = IDU_Valid & ~stall;
    assign set_entry  = accept & IDU_IsLoad & (IDU_DstReg != '0);
    assign Stall      = stall;

    // NOTE: the scoreboard is a small flop array, not RAM, so it is cleared by the async reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) sb_cnt[i] <= 3'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: sequential state uses non-blocking assignment so all flops update together.
                if (set_entry && IDU_DstReg == REG_AW'(i)) begin
                    sb_cnt[i] <= LOAD_CNT;
                end else if (sb_cnt[i] != 3'd0) begin
                    sb_cnt[i] <= sb_cnt[i] - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            ctrl_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            ctrl_cnt <= ctrl_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        ctrl_cnt_next = ctrl_cnt;
        case (state)
            IDLE: begin
                if (accept && IDU_Jump) begin
                    state_next    = CTRL_WAIT;
                    ctrl_cnt_next = BRANCH_CNT;
                end
            end
            CTRL_WAIT: begin
                if (ctrl_cnt <= 3'd1) begin
                    state_next    = IDLE;
                    ctrl_cnt_next = 3'd0;
                end else begin
                    ctrl_cnt_next = ctrl_cnt - 3'd1;
                end
            end
            default: begin
                state_next    = IDLE;
                ctrl_cnt_next = 3'd0;
            end
        endcase
    end

    always_comb begin
        hazard = HZ_NONE;
        if (Reset)           hazard = HZ_RESET;
        else if (ctrl_stall) hazard = HZ_CONTROL;
        else if (load_use)   hazard = HZ_LOAD_USE;
    end

    assign HazardType = hazard;

`ifdef HDU_STALL_COUNT_EN
    logic [15:0] stall_count;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_count <= 16'd0;
        end else if (stall && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    assign StallCount = stall_count;
`else
    assign StallCount = 16'd0;
`endif

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 The block SHALL provide parameter NUM_REGS, default 32, meaning the architectural register count.
REQ-002 The block SHALL provide parameter REG_AW, default 5, meaning the register address width, with NUM_REGS <= 2**REG_AW.
REQ-003 The block SHALL provide parameter LOAD_LATENCY, default 1, range 1..7, meaning the cycles before a load result is forwardable to ID.
REQ-004 The block SHALL provide parameter BRANCH_PENALTY, default 2, range 1..7, meaning the stall cycles after a branch or jump is accepted in ID.
REQ-005 The block SHALL have port Clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port IDU_Valid, input, 1 bit: the ID stage holds a real instruction.
REQ-008 The block SHALL have ports IDU_RsReg and IDU_RtReg, input, REG_AW bits each: the source registers.
REQ-009 The block SHALL have ports IDU_UsesRs and IDU_UsesRt, input, 1 bit each: the matching source is actually read.
REQ-010 The block SHALL have port IDU_DstReg, input, REG_AW bits: the destination register.
REQ-011 The block SHALL have port IDU_IsLoad, input, 1 bit: the ID instruction is a load writing IDU_DstReg.
REQ-012 The block SHALL have port IDU_Jump, input, 1 bit: the ID instruction is a branch, jump or JAL.
REQ-013 The block SHALL have port Stall, output, 1 bit: freeze PC and IF/ID and insert a bubble into EX.
REQ-014 The block SHALL have port HazardType, output, 2 bits: 00 none, 01 load-use, 10 control, 11 reset.
REQ-015 The block SHALL have port StallCount, output, 16 bits: the stall statistics counter.

Function
REQ-016 The block SHALL hold one scoreboard counter per register, each 3 bits wide, where a non-zero value means the result is pending.
REQ-017 An instruction SHALL be accepted when IDU_Valid=1 and Stall=0 on a rising Clk edge.
REQ-018 On accepting a load with IDU_DstReg != 0, the block SHALL load counter[IDU_DstReg] with LOAD_LATENCY, overwriting any value already held.
REQ-019 Every other non-zero counter SHALL decrement by 1 each cycle.
REQ-020 Register 0 SHALL never be marked pending.
REQ-021 A load-use hazard SHALL exist when IDU_Valid=1 and ((IDU_UsesRs and counter[IDU_RsReg] != 0) or (IDU_UsesRt and counter[IDU_RtReg] != 0)).
REQ-022 The dependent instruction SHALL therefore stall exactly LOAD_LATENCY cycles.
REQ-023 The control FSM SHALL have two states, IDLE and CTRL_WAIT, with a 3-bit down-counter.
REQ-024 In IDLE, accepting an instruction with IDU_Jump=1 SHALL move the FSM to CTRL_WAIT with the counter set to BRANCH_PENALTY.
REQ-025 In CTRL_WAIT, the FSM SHALL assert a control stall, decrement the counter each cycle, and return to IDLE on the cycle after the counter reaches 1.
REQ-026 Stall SHALL be combinational: (Reset) or (state == CTRL_WAIT) or (load-use hazard).
REQ-027 HazardType SHALL use the priority reset > control > load-use.
REQ-028 When a load-use hazard and a jump coincide in ID, the jump SHALL NOT be accepted until the hazard clears, after which it is accepted normally.
REQ-029 While Stall=1, no scoreboard entry SHALL be set, but counters SHALL keep decrementing.
REQ-030 IDU_Valid=0 SHALL never cause a load-use hazard, an entry set, or a jump acceptance.

Reset
REQ-031 Asserting Reset SHALL asynchronously clear all scoreboard counters, force the FSM to IDLE with its counter at 0, and clear StallCount.
REQ-032 While Reset=1, the block SHALL drive Stall=1 and HazardType=11.
REQ-033 A reset asserted mid-stall SHALL abandon the stall, and the first cycle after release SHALL show Stall=0 unless a new hazard exists.

Configuration
REQ-034 With macro HDU_STALL_COUNT_EN defined, StallCount SHALL increment by 1 on every Clk edge where Stall=1 and Reset=0, saturating at 16'hFFFF.
REQ-035 Without HDU_STALL_COUNT_EN, StallCount SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-036 Load $5 accepted, then ADD reading $5 in the next cycle, LOAD_LATENCY=1 -> Stall=1 and HazardType=01 for exactly 1 cycle, then the ADD is accepted.
REQ-037 LOAD_LATENCY=3, load $7, then a consumer of $7 -> 3 stall cycles; a consumer of $8 instead -> 0 stall cycles.
REQ-038 Load to $0, then a consumer of $0 -> Stall=0 throughout.
REQ-039 BEQ accepted with BRANCH_PENALTY=2 -> Stall=1 and HazardType=10 for exactly 2 cycles, FSM back in IDLE on the 3rd.
REQ-040 A jump arriving in ID while a load-use hazard is pending -> load-use stall first, then 2 control-stall cycles, with StallCount = 3 when HDU_STALL_COUNT_EN is defined.
REQ-041 Reset pulsed during the 2nd control-stall cycle -> Stall=1 and HazardType=11 during reset, Stall=0 after release, and all counters zero.
